hamming_pad_decode: RTL and testbench
=====================================

Name: hamming_pad_decode

Overview:
- Receive side of the serial ECC link: sits behind the deserializer shift register.
- Takes a received data field plus its Hamming check bits, assembles the SECDED codeword (pad step), then decodes it.
- Corrects any single-bit error, detects double-bit errors, and reports the fault position and error count.
- All outputs are registered, with one cycle of latency.

Parameters:
- DATA_WIDTH, 8, payload width in bits (minimum 4).
- PARITY_BITS, derived (4 at default), smallest r with 2^r >= DATA_WIDTH+r+1.
- CODE_BITS, derived (5 at default), PARITY_BITS+1 (Hamming parity bits plus overall parity).
- CODED_WIDTH, derived (13 at default), DATA_WIDTH+CODE_BITS.
- ADDR_WIDTH, derived (4 at default), $clog2(CODED_WIDTH).

Ports:
- clk_i in 1: clock, rising edge.
- rst_n_i in 1: reset; one clock; reset is asynchronous and active-low.
- valid_i in 1: data_in_i and pad_bits_i are valid this cycle.
- data_in_i in DATA_WIDTH: received payload, possibly corrupted.
- pad_bits_i in CODE_BITS: received check bits; bit0 = overall parity, bit k+1 = parity for position 2^k.
- valid_o out 1: registered outputs are valid.
- codeword_o out CODED_WIDTH: assembled codeword; bit index = Hamming position.
- raw_data_o out DATA_WIDTH: uncorrected payload.
- data_out_o out DATA_WIDTH: corrected payload.
- fault_location_o out ADDR_WIDTH: position of the corrected bit.
- num_errors_o out 2: 0 = clean, 1 = corrected, 2 = double error, 3 = invalid syndrome.

Behaviour:
- Pad mapping (combinational):
  - Codeword position 0 = pad_bits_i[0].
  - Position 2^k = pad_bits_i[k+1].
  - Data bits fill the non-power-of-two positions 3,5,6,7,9,... in ascending order, data_in_i[0] first.
- Encoding convention (even parity):
  - Parity at 2^k = XOR of all positions 1..CODED_WIDTH-1 whose index has bit k set.
  - Overall parity makes the XOR of all CODED_WIDTH bits equal 0.
- Decode (combinational):
  - syndrome S = XOR of the indices of all set bits in positions 1..CODED_WIDTH-1.
  - P = XOR of all codeword bits.
- Classification:
  - S=0, P=0: num_errors 0, fault_location 0, data_out = raw.
  - P=1, S<CODED_WIDTH: single error; flip position S (S=0 means the overall parity bit); num_errors 1, fault_location S; data_out = corrected data bits.
  - S!=0, P=0: double error; num_errors 2, fault_location 0, data_out = raw (no correction).
  - P=1, S>=CODED_WIDTH: num_errors 3, fault_location 0, data_out = raw.
- Registering:
  - When valid_i=1, all outputs load on the rising edge; valid_o follows valid_i one cycle later.
  - When valid_i=0, valid_o goes 0 and the data outputs hold their last values.
- Reset: every output clears to 0 immediately on rst_n_i low (asynchronous), including mid-stream.
- Back-to-back words: one word per clock, no stall.

Test Plan:
- Clean word: data_in 0xA5, pad 0x06, valid_i=1 -> next cycle:
  - valid_o=1, codeword 0x144E
  - data_out 0xA5, raw 0xA5
  - num_errors 0, fault_location 0.
- Single data error: data_in 0xA1, pad 0x06 -> data_out 0xA5, raw 0xA1, num_errors 1, fault_location 6.
- Parity-bit errors:
  - data_in 0xA5, pad 0x07 -> num_errors 1, fault_location 0, data_out 0xA5.
  - data_in 0xA5, pad 0x04 -> num_errors 1, fault_location 1, data_out 0xA5.
- Double error: data_in 0xA6, pad 0x06 -> num_errors 2, fault_location 0, data_out 0xA6.
- Exhaustive sweep: all 256 payloads × each of the 13 single-bit flips -> data_out always equals the original payload and fault_location equals the flipped position; all 78 double flips -> num_errors 2.
- Control:
  - Assert rst_n_i low between valid cycles -> all outputs 0 immediately.
  - Back-to-back valid words -> one result per cycle, in order.
  - valid_i=0 -> valid_o=0 and data outputs hold.

Source files
------------

// File: rtl/hamming_pad_decode.sv
// SECDED receive decoder: assembles the Hamming codeword from payload and check
// bits, corrects single errors, flags double/invalid errors; one registered stage.
module hamming_pad_decode #(
    parameter int DATA_WIDTH = 8,
    localparam int PARITY_BITS = (DATA_WIDTH <= 4)   ? 3 :
                                 (DATA_WIDTH <= 11)  ? 4 :
                                 (DATA_WIDTH <= 26)  ? 5 :
                                 (DATA_WIDTH <= 57)  ? 6 :
                                 (DATA_WIDTH <= 120) ? 7 :
                                 (DATA_WIDTH <= 247) ? 8 :
                                 (DATA_WIDTH <= 502) ? 9 : 10,
    localparam int CODE_BITS   = PARITY_BITS + 1,
    localparam int CODED_WIDTH = DATA_WIDTH + CODE_BITS,
    localparam int ADDR_WIDTH  = $clog2(CODED_WIDTH)
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   valid_i,
    input  logic [DATA_WIDTH-1:0]  data_in_i,
    input  logic [CODE_BITS-1:0]   pad_bits_i,
    output logic                   valid_o,
    output logic [CODED_WIDTH-1:0] codeword_o,
    output logic [DATA_WIDTH-1:0]  raw_data_o,
    output logic [DATA_WIDTH-1:0]  data_out_o,
    output logic [ADDR_WIDTH-1:0]  fault_location_o,
    output logic [1:0]             num_errors_o
);

    // One extra bit so the bound still fits when CODED_WIDTH is a power of two.
    localparam logic [ADDR_WIDTH:0] CODED_LIMIT = CODED_WIDTH[ADDR_WIDTH:0];

    logic [CODED_WIDTH-1:0] cw_w;
    logic [CODED_WIDTH-1:0] fixed_w;
    logic [ADDR_WIDTH-1:0]  syn_w;
    logic                   par_w;
    logic                   single_w;
    logic [DATA_WIDTH-1:0]  corr_w;
    logic [ADDR_WIDTH-1:0]  loc_w;
    logic [1:0]             num_w;

    logic                   valid_q;
    logic [CODED_WIDTH-1:0] codeword_q;
    logic [DATA_WIDTH-1:0]  raw_q;
    logic [DATA_WIDTH-1:0]  data_out_q;
    logic [ADDR_WIDTH-1:0]  loc_q;
    logic [1:0]             num_q;

    // Powers of two take check bits in order; all other positions take payload bits.
    always_comb begin
        int j;
        int k;
        cw_w    = '0;
        cw_w[0] = pad_bits_i[0];
        j       = 0;
        k       = 1;
        for (int p = 1; p < CODED_WIDTH; p++) begin
            if ((p & (p - 1)) == 0) begin
                cw_w[p] = pad_bits_i[k];
                k++;
            end else begin
                cw_w[p] = data_in_i[j];
                j++;
            end
        end
    end

    always_comb begin
        int j;
        syn_w = '0;
        par_w = ^cw_w;
        for (int p = 1; p < CODED_WIDTH; p++) begin
            if (cw_w[p]) syn_w = syn_w ^ p[ADDR_WIDTH-1:0];
        end

        single_w = par_w && ({1'b0, syn_w} < CODED_LIMIT);

        fixed_w = cw_w;
        for (int p = 0; p < CODED_WIDTH; p++) begin
            if (single_w && (syn_w == p[ADDR_WIDTH-1:0])) fixed_w[p] = ~cw_w[p];
        end

        corr_w = '0;
        j      = 0;
        for (int p = 1; p < CODED_WIDTH; p++) begin
            if ((p & (p - 1)) != 0) begin
                corr_w[j] = fixed_w[p];
                j++;
            end
        end

        if (!par_w && syn_w == '0) begin
            num_w = 2'd0;
        end else if (single_w) begin
            num_w = 2'd1;
        end else if (!par_w) begin
            num_w = 2'd2;
        end else begin
            num_w = 2'd3;
        end
        loc_w = single_w ? syn_w : '0;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_q    <= 1'b0;
            codeword_q <= '0;
            raw_q      <= '0;
            data_out_q <= '0;
            loc_q      <= '0;
            num_q      <= '0;
        end else begin
            valid_q <= valid_i;
            if (valid_i) begin
                codeword_q <= cw_w;
                raw_q      <= data_in_i;
                data_out_q <= single_w ? corr_w : data_in_i;
                loc_q      <= loc_w;
                num_q      <= num_w;
            end
        end
    end

    assign valid_o          = valid_q;
    assign codeword_o       = codeword_q;
    assign raw_data_o       = raw_q;
    assign data_out_o       = data_out_q;
    assign fault_location_o = loc_q;
    assign num_errors_o     = num_q;

endmodule

// File: tb/tb_hamming_pad_decode.sv
// Bench for hamming_pad_decode: directed vector table, exhaustive single/double
// flip sweeps, randomized traffic with idle gaps, and asynchronous reset checks.
module tb_hamming_pad_decode;

    localparam int DW = 8;
    localparam int CW = 13;
    localparam int AW = 4;
    localparam int PB = 5;
    localparam int DATA_POS [DW] = '{3, 5, 6, 7, 9, 10, 11, 12};

    logic          clk_i = 1'b0;
    logic          rst_n_i;
    logic          valid_i;
    logic [DW-1:0] data_in_i;
    logic [PB-1:0] pad_bits_i;
    logic          valid_o;
    logic [CW-1:0] codeword_o;
    logic [DW-1:0] raw_data_o;
    logic [DW-1:0] data_out_o;
    logic [AW-1:0] fault_location_o;
    logic [1:0]    num_errors_o;

    int tests = 0;
    int fails = 0;

    logic [CW-1:0] last_cw;
    logic [DW-1:0] last_raw;
    logic [DW-1:0] last_out;
    logic [AW-1:0] last_loc;
    logic [1:0]    last_num;

    typedef struct {
        logic [DW-1:0] d;
        logic [PB-1:0] p;
        logic [CW-1:0] cw;
        logic [DW-1:0] out;
        logic [AW-1:0] loc;
        logic [1:0]    num;
    } vec_t;

    vec_t vecs [6];

    always #5 clk_i = ~clk_i;

    hamming_pad_decode #(.DATA_WIDTH(DW)) dut (
        .clk_i            (clk_i),
        .rst_n_i          (rst_n_i),
        .valid_i          (valid_i),
        .data_in_i        (data_in_i),
        .pad_bits_i       (pad_bits_i),
        .valid_o          (valid_o),
        .codeword_o       (codeword_o),
        .raw_data_o       (raw_data_o),
        .data_out_o       (data_out_o),
        .fault_location_o (fault_location_o),
        .num_errors_o     (num_errors_o)
    );

    // Reference model: a clean codeword built straight from the even-parity rule.
    function automatic logic [CW-1:0] encode(input logic [DW-1:0] d);
        logic [CW-1:0] c;
        logic x;
        c = '0;
        for (int i = 0; i < DW; i++) c[DATA_POS[i]] = d[i];
        for (int k = 0; k < 4; k++) begin
            x = 1'b0;
            for (int p = 1; p < CW; p++)
                if (p != (1 << k) && ((p >> k) & 1) == 1) x = x ^ c[p];
            c[1 << k] = x;
        end
        c[0] = ^c[CW-1:1];
        return c;
    endfunction

    function automatic logic [DW-1:0] data_of(input logic [CW-1:0] c);
        logic [DW-1:0] d;
        for (int i = 0; i < DW; i++) d[i] = c[DATA_POS[i]];
        return d;
    endfunction

    function automatic logic [PB-1:0] pad_of(input logic [CW-1:0] c);
        return {c[8], c[4], c[2], c[1], c[0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic v, input logic [CW-1:0] cw,
                             input logic [DW-1:0] raw, input logic [DW-1:0] out,
                             input logic [AW-1:0] loc, input logic [1:0] num);
        check({tag, ".valid"}, 32'(valid_o), 32'(v));
        check({tag, ".codeword"}, 32'(codeword_o), 32'(cw));
        check({tag, ".raw"}, 32'(raw_data_o), 32'(raw));
        check({tag, ".data_out"}, 32'(data_out_o), 32'(out));
        check({tag, ".fault_loc"}, 32'(fault_location_o), 32'(loc));
        check({tag, ".num_errors"}, 32'(num_errors_o), 32'(num));
    endtask

    task automatic drive(input logic [DW-1:0] d, input logic [PB-1:0] p);
        @(negedge clk_i);
        valid_i    = 1'b1;
        data_in_i  = d;
        pad_bits_i = p;
        @(posedge clk_i);
        #1;
    endtask

    // Sends payload d with the codeword bits in mask flipped; expectations come
    // from how many bits were flipped, not from any syndrome arithmetic.
    task automatic run_mask(input string tag, input logic [DW-1:0] d, input logic [CW-1:0] mask);
        logic [CW-1:0] bad;
        logic [AW-1:0] loc;
        logic [1:0]    num;
        logic [DW-1:0] out;
        bad = encode(d) ^ mask;
        loc = '0;
        case ($countones(mask))
            0:       begin num = 2'd0; out = d; end
            1:       begin
                num = 2'd1;
                out = d;
                for (int i = 0; i < CW; i++) if (mask[i]) loc = AW'(i);
            end
            default: begin num = 2'd2; out = data_of(bad); end
        endcase
        drive(data_of(bad), pad_of(bad));
        check_all(tag, 1'b1, bad, data_of(bad), out, loc, num);
        last_cw  = bad;
        last_raw = data_of(bad);
        last_out = out;
        last_loc = loc;
        last_num = num;
    endtask

    task automatic idle_hold(input string tag);
        @(negedge clk_i);
        valid_i    = 1'b0;
        data_in_i  = DW'($urandom);
        pad_bits_i = PB'($urandom);
        @(posedge clk_i);
        #1;
        check_all(tag, 1'b0, last_cw, last_raw, last_out, last_loc, last_num);
    endtask

    initial begin
        logic [CW-1:0] mask;
        int f1;
        int f2;
        int n;

        vecs[0] = '{d: 8'hA5, p: 5'h06, cw: 13'h144E, out: 8'hA5, loc: 4'd0, num: 2'd0};
        vecs[1] = '{d: 8'hA1, p: 5'h06, cw: 13'h140E, out: 8'hA5, loc: 4'd6, num: 2'd1};
        vecs[2] = '{d: 8'hA5, p: 5'h07, cw: 13'h144F, out: 8'hA5, loc: 4'd0, num: 2'd1};
        vecs[3] = '{d: 8'hA5, p: 5'h04, cw: 13'h144C, out: 8'hA5, loc: 4'd1, num: 2'd1};
        vecs[4] = '{d: 8'hA6, p: 5'h06, cw: 13'h1466, out: 8'hA6, loc: 4'd0, num: 2'd2};
        vecs[5] = '{d: 8'hA5, p: 5'h1C, cw: 13'h155C, out: 8'hA5, loc: 4'd0, num: 2'd3};

        rst_n_i    = 1'b0;
        valid_i    = 1'b0;
        data_in_i  = '0;
        pad_bits_i = '0;
        #1;
        check_all("reset", 1'b0, '0, '0, '0, '0, 2'd0);
        repeat (2) @(negedge clk_i);
        rst_n_i = 1'b1;

        for (int i = 0; i < 6; i++) begin
            drive(vecs[i].d, vecs[i].p);
            check_all($sformatf("vec%0d", i), 1'b1, vecs[i].cw, vecs[i].d,
                      vecs[i].out, vecs[i].loc, vecs[i].num);
        end
        last_cw  = vecs[5].cw;
        last_raw = vecs[5].d;
        last_out = vecs[5].out;
        last_loc = vecs[5].loc;
        last_num = vecs[5].num;
        idle_hold("hold_after_vec");

        // Asynchronous reset mid-stream, away from any clock edge.
        drive(8'h3C, pad_of(encode(8'h3C)));
        #2;
        rst_n_i = 1'b0;
        #1;
        check_all("async_reset", 1'b0, '0, '0, '0, '0, 2'd0);
        @(negedge clk_i);
        valid_i = 1'b0;
        rst_n_i = 1'b1;

        for (int d = 0; d < 256; d++)
            for (int f = 0; f < CW; f++)
                run_mask("single", DW'(d), CW'(1) << f);

        for (int d = 0; d < 256; d++)
            for (int a = 0; a < CW; a++)
                for (int b = a + 1; b < CW; b++)
                    run_mask("double", DW'(d), (CW'(1) << a) | (CW'(1) << b));

        for (int t = 0; t < 400; t++) begin
            n    = $urandom_range(0, 2);
            f1   = $urandom_range(0, CW - 1);
            f2   = (f1 + $urandom_range(1, CW - 1)) % CW;
            mask = '0;
            if (n >= 1) mask[f1] = 1'b1;
            if (n == 2) mask[f2] = 1'b1;
            run_mask("random", DW'($urandom), mask);
            if ($urandom_range(0, 3) == 0) idle_hold("random_hold");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
